// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and hex-to-segment decode for the 7-seg scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segments, a..g at bits 6..0, indexed by hex nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_lz_mask.sv
// ============================================================================
// Module   : seg7_lz_mask
// Purpose  : Leading-zero suppression mask; digit 0 is never suppressed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_lz_mask #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   suppress
);

  // zero_run[i]: digit i and every digit above it hold a zero nibble.
  logic [NUM_DIGITS-1:0] zero_run;

  assign zero_run[0] = 1'b0;

  generate
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_digit
      logic nib_zero;
      assign nib_zero = (value[4*i +: 4] == 4'h0);
      if (i == NUM_DIGITS - 1) begin : g_top
        assign zero_run[i] = nib_zero;
      end else begin : g_lower
        assign zero_run[i] = nib_zero & zero_run[i+1];
      end
    end
  endgenerate

  assign suppress = zero_run & {NUM_DIGITS{lz_suppress}};

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Multiplexed 7-seg scanner with PWM, blanking, LZ suppression and
//            double-buffered, frame-aligned updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 16,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              a_to_g,
  output logic                    dp,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_act_q, val_act_d, val_shd_q, val_shd_d;
  logic [NUM_DIGITS-1:0]   dp_act_q, dp_act_d, dp_shd_q, dp_shd_d;
  logic [NUM_DIGITS-1:0]   blank_act_q, blank_act_d, blank_shd_q, blank_shd_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_end;
  logic                    boundary;
  logic [3:0]              nibble;
  logic                    digit_on;
  logic [NUM_DIGITS-1:0]   suppress;

  seg7_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .value       (val_act_q),
    .lz_suppress (lz_suppress),
    .suppress    (suppress)
  );

  always_comb begin
    slot_end    = &div_cnt_q;
    boundary    = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    div_cnt_d   = div_cnt_q + DIV_W'(1);
    idx_d       = idx_q;
    val_act_d   = val_act_q;
    dp_act_d    = dp_act_q;
    blank_act_d = blank_act_q;
    val_shd_d   = val_shd_q;
    dp_shd_d    = dp_shd_q;
    blank_shd_d = blank_shd_q;
    pending_d   = pending_q;

    if (slot_end) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end

    // A load landing on the boundary bypasses the shadow so it is not lost a frame.
    if (load && boundary) begin
      val_act_d   = value;
      dp_act_d    = dp_in;
      blank_act_d = blank_in;
      pending_d   = 1'b0;
    end else if (boundary && pending_q) begin
      val_act_d   = val_shd_q;
      dp_act_d    = dp_shd_q;
      blank_act_d = blank_shd_q;
      pending_d   = 1'b0;
    end

    if (load) begin
      val_shd_d   = value;
      dp_shd_d    = dp_in;
      blank_shd_d = blank_in;
      if (!boundary) begin
        pending_d = 1'b1;
      end
    end

    nibble   = val_act_q[{idx_q, 2'b00} +: 4];
    // div_cnt == 0 is a forced dark cycle so the previous digit cannot ghost.
    digit_on = !blank_act_q[idx_q] && !suppress[idx_q] && (div_cnt_q != '0) &&
               (div_cnt_q[DIV_W-1 -: BRIGHT_W] < brightness);

    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (digit_on) begin
      an_d  = ~(DIGIT_ONE << idx_q);
      seg_d = seg7_decode(nibble);
      dp_d  = ~dp_act_q[idx_q];
    end

    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      val_act_q    <= '0;
      dp_act_q     <= '0;
      blank_act_q  <= '0;
      val_shd_q    <= '0;
      dp_shd_q     <= '0;
      blank_shd_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      val_act_q    <= val_act_d;
      dp_act_q     <= dp_act_d;
      blank_act_q  <= blank_act_d;
      val_shd_q    <= val_shd_d;
      dp_shd_q     <= dp_shd_d;
      blank_shd_q  <= blank_shd_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an             = an_q;
  assign a_to_g         = seg_q;
  assign dp             = dp_q;
  assign update_pending = pending_q;
  assign frame_done     = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Directed, table-driven bench for seg7_scan_ctrl (4 digits, 64-cycle frame).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BW    = 2;
  localparam int FRAME = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [1:0]    brightness = '0;
  logic [3:0]    an;
  logic [6:0]    a_to_g;
  logic          dp;
  logic          update_pending;
  logic          frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DIV_W      (DW),
    .BRIGHT_W   (BW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .value          (value),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .load           (load),
    .lz_suppress    (lz_suppress),
    .brightness     (brightness),
    .an             (an),
    .a_to_g         (a_to_g),
    .dp             (dp),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz;
    logic [1:0]  br;
    int          idx;
    int          div;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [22];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;     // rising edges since the last reset release

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_to(input int target);
    while (t < target) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    int tl;
    int fs;

    vecs[0]  = '{16'h0000, 4'h0, 4'h0, 1'b0, 2'd3, 0,  5, 4'b1110, 7'h01, 1'b1};
    vecs[1]  = '{16'h0000, 4'h0, 4'h0, 1'b0, 2'd3, 0,  0, 4'b1111, 7'h7F, 1'b1};
    vecs[2]  = '{16'h0000, 4'h0, 4'h0, 1'b0, 2'd3, 0, 11, 4'b1110, 7'h01, 1'b1};
    vecs[3]  = '{16'h0000, 4'h0, 4'h0, 1'b0, 2'd3, 0, 12, 4'b1111, 7'h7F, 1'b1};
    vecs[4]  = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd3, 0,  1, 4'b1110, 7'h38, 1'b1};
    vecs[5]  = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd3, 1,  6, 4'b1101, 7'h08, 1'b1};
    vecs[6]  = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd3, 2,  3, 4'b1011, 7'h12, 1'b0};
    vecs[7]  = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd3, 3, 11, 4'b0111, 7'h4F, 1'b1};
    vecs[8]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 3,  5, 4'b1111, 7'h7F, 1'b1};
    vecs[9]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 2,  5, 4'b1111, 7'h7F, 1'b1};
    vecs[10] = '{16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 1,  5, 4'b1101, 7'h24, 1'b1};
    vecs[11] = '{16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 0,  5, 4'b1110, 7'h01, 1'b1};
    vecs[12] = '{16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 1,  5, 4'b1111, 7'h7F, 1'b1};
    vecs[13] = '{16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 0,  5, 4'b1110, 7'h01, 1'b1};
    vecs[14] = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd0, 0,  1, 4'b1111, 7'h7F, 1'b1};
    vecs[15] = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd1, 2,  3, 4'b1011, 7'h12, 1'b0};
    vecs[16] = '{16'h12AF, 4'h4, 4'h0, 1'b0, 2'd1, 2,  4, 4'b1111, 7'h7F, 1'b1};
    vecs[17] = '{16'h12AF, 4'h0, 4'h2, 1'b0, 2'd3, 1,  5, 4'b1111, 7'h7F, 1'b1};
    vecs[18] = '{16'h0050, 4'h8, 4'h0, 1'b1, 2'd3, 3,  2, 4'b1111, 7'h7F, 1'b1};
    vecs[19] = '{16'h1000, 4'h0, 4'h8, 1'b1, 2'd3, 2,  5, 4'b1011, 7'h01, 1'b1};
    vecs[20] = '{16'h12AF, 4'h4, 4'h0, 1'b1, 2'd3, 3,  7, 4'b0111, 7'h4F, 1'b1};
    vecs[21] = '{16'h0050, 4'h2, 4'h0, 1'b1, 2'd3, 1,  9, 4'b1101, 7'h24, 1'b0};

    // Reset state, then the first cycles after release are dark.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {an, a_to_g, dp, frame_done, update_pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    t   = 0;
    chk("first_cycle", {an, a_to_g, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    step();
    chk("first_slot_dead", {an, a_to_g, dp}, {4'hF, 7'h7F, 1'b1});

    // Table: load, then check a given (digit, div_cnt) point of the next frame.
    foreach (vecs[i]) begin
      if (t % FRAME == FRAME - 1) step();
      lz_suppress = vecs[i].lz;
      brightness  = vecs[i].br;
      tl = t;
      do_load(vecs[i].value, vecs[i].dp_in, vecs[i].blank);
      chk($sformatf("v%0d_pending", i), {31'd0, update_pending}, 32'd1);
      fs = (tl / FRAME + 1) * FRAME;
      wait_to(fs + 16 * vecs[i].idx + vecs[i].div + 1);
      chk($sformatf("v%0d_display", i), {an, a_to_g, dp}, {vecs[i].an, vecs[i].seg, vecs[i].dp});
    end

    // frame_done pulses exactly once per 64 cycles.
    lz_suppress = 1'b0;
    brightness  = 2'd3;
    repeat (130) begin
      step();
      chk("frame_done", {31'd0, frame_done}, {31'd0, (t % FRAME == 0)});
    end

    // Mid-frame load: old data holds until the boundary.
    fs = (t / FRAME + 1) * FRAME;
    wait_to(fs + 10);
    do_load(16'h7777, 4'h0, 4'h0);
    fs = fs + FRAME;
    wait_to(fs + 6);
    chk("old_value_d0", {an, a_to_g}, {4'b1110, 7'h0F});
    wait_to(fs + 20);
    do_load(16'h9999, 4'h0, 4'h0);
    chk("midframe_pending", {31'd0, update_pending}, 32'd1);
    wait_to(fs + 16 * 3 + 5 + 1);
    chk("old_value_d3", {an, a_to_g}, {4'b0111, 7'h0F});
    wait_to(fs + FRAME - 1);
    chk("pending_before_wrap", {31'd0, update_pending}, 32'd1);
    step();
    chk("pending_after_wrap", {31'd0, update_pending}, 32'd0);
    fs = fs + FRAME;
    wait_to(fs + 6);
    chk("new_value_d0", {an, a_to_g}, {4'b1110, 7'h04});

    // Two loads in one frame (last wins), then a load on the wrap cycle.
    do_load(16'h1111, 4'h0, 4'h0);
    do_load(16'h2222, 4'h0, 4'h0);
    fs = fs + FRAME;
    wait_to(fs + 6);
    chk("last_load_wins", {an, a_to_g, update_pending}, {4'b1110, 7'h12, 1'b0});
    wait_to(fs + FRAME - 1);
    do_load(16'h3333, 4'h0, 4'h0);
    chk("wrap_load_no_pending", {31'd0, update_pending}, 32'd0);
    fs = fs + FRAME;
    wait_to(fs + 6);
    chk("wrap_load_d0", {an, a_to_g}, {4'b1110, 7'h06});
    wait_to(fs + 16 * 3 + 5 + 1);
    chk("wrap_load_d3", {an, a_to_g, update_pending}, {4'b0111, 7'h06, 1'b0});

    // Asynchronous reset mid-frame discards a pending shadow.
    do_load(16'h8888, 4'h0, 4'h0);
    fs = (t / FRAME + 1) * FRAME;
    wait_to(fs + 5);
    do_load(16'hEEEE, 4'h0, 4'h0);
    chk("pre_reset_lit", {an, a_to_g, update_pending}, {4'b1110, 7'h00, 1'b1});
    rst = 1'b0;
    #1;
    chk("async_reset", {an, a_to_g, dp, frame_done, update_pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    step();
    step();
    rst = 1'b1;
    t   = 0;
    wait_to(6);
    chk("post_reset_d0", {an, a_to_g, update_pending}, {4'b1110, 7'h01, 1'b0});
    wait_to(FRAME + 6);
    chk("shadow_discarded", {an, a_to_g, update_pending}, {4'b1110, 7'h01, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller driving the SoC board pins `an` / `a_to_g`. Scans NUM_DIGITS hex digits with a programmable refresh period and adds hex decode, per-digit blanking, decimal points, leading-zero suppression, PWM brightness and tear-free double-buffered updates. Sits at SoC top, written by the CPU-side MMIO register block through a load strobe.

## Interface
- NUM_DIGITS, 8: number of digits / anodes (2..16)
- DIV_W, 16: refresh counter width; each digit slot lasts 2**DIV_W cycles
- BRIGHT_W, 4: brightness field width (BRIGHT_W <= DIV_W)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 least significant
- dp_in  in  NUM_DIGITS  decimal point enable per digit
- blank_in  in  NUM_DIGITS  force digit i dark
- load  in  1  single-cycle strobe capturing value/dp_in/blank_in
- lz_suppress  in  1  leading-zero suppression enable (sampled live)
- brightness  in  BRIGHT_W  duty = brightness / 2**BRIGHT_W; 0 = dark
- an  out  NUM_DIGITS  anodes, active-low
- a_to_g  out  7  segments a..g at bits 6..0, active-low
- dp  out  1  decimal point, active-low
- update_pending  out  1  shadow loaded, not yet applied
- frame_done  out  1  one-cycle pulse at end of full scan

## Operation
- Counters: div_cnt (DIV_W bits) increments every cycle; at all-ones wraps to 0 and digit index idx advances; idx wraps NUM_DIGITS-1 -> 0 (frame boundary).
- Buffers: load copies inputs to shadow and sets pending; at a frame boundary with pending set, shadow -> active, pending clears. Multiple loads before boundary: last wins. Load in the boundary cycle: incoming data goes straight to active, pending stays 0.
- Digit enable for idx: not blank, not leading-zero-suppressed, div_cnt != 0 (one-cycle dead time against ghosting), and div_cnt[DIV_W-1 -: BRIGHT_W] < brightness.
- Leading-zero suppression (lz_suppress=1): from digit NUM_DIGITS-1 downward, zero nibbles are suppressed until first nonzero; digit 0 never suppressed. Suppressed digit's dp also dark. Blanked digits still count as their nibble value for suppression.
- Enabled: an = ~(1<<idx), a_to_g = decode(nibble), dp = ~dp_active[idx]. Disabled: an, a_to_g, dp all ones.
- Decode (active-low): 0=0000001, 1=1001111, 8=0000000, F=0111000, full 0..F table in package.

## Timing
- Reset (rst=0, async): an all ones, a_to_g 7'h7F, dp 1, frame_done 0, update_pending 0, div_cnt 0, idx 0, active and shadow buffers 0.
- All outputs registered: reflect div_cnt/idx/active of previous cycle (1-cycle latency).
- frame_done high in the cycle after the boundary (coincides with first output cycle of digit 0 slot of new frame).
- update_pending rises the cycle after load, falls the cycle after applying boundary.
- Max visible latency load -> display: one frame + 1 cycle = NUM_DIGITS*2**DIV_W + 1.
- Reset mid-frame discards pending shadow; scan restarts at digit 0.

## Structure
- Package seg7_pkg: 16-entry hex-to-segment constant table (active-low), SEG_OFF = 7'h7F, decode function.
- One sub-module seg7_lz_mask: combinational, value + lz_suppress -> NUM_DIGITS suppress mask.
- Counters, buffers and output registers stay in top.

## Test plan
Bench: NUM_DIGITS=4, DIV_W=4, BRIGHT_W=2.
- Reset release, no load -> an=4'b1111 entire first cycle; after load value=16'h0000, brightness=3: digit 0 shows 0000001 on an=1110 for cycles 1..11 of each slot, dark cycle 0 and 12..15.
- load value=16'h12AF, blank_in=0, dp_in=4'b0100, brightness=3 -> after next boundary digits show F(0111000), A, 2 with dp=0, 1(1001111); an sequence 1110,1101,1011,0111.
- Load mid-frame -> update_pending=1, old value shown until boundary, new value from digit 0 of next frame; frame_done pulse every 64 cycles.
- lz_suppress=1, value=16'h0050 -> digits 3,2 dark, digits 1 (5) and 0 (0) lit; value=16'h0000 -> only digit 0 lit.
- brightness=0 -> an stays 1111 for whole frame; brightness=1 -> each digit lit cycles 1..3 only.
- Two loads before boundary (16'h1111 then 16'h2222), plus load coincident with wrap (16'h3333) -> display shows 2222, then 3333 with update_pending=0; assert rst mid-frame -> outputs all ones asynchronously, buffers cleared.
